holding_fifo: RTL

//   Parametrised successor to the single-word holding register: a depth-N

---
 rtl/holding_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/holding_fifo.sv
`default_nettype none
// ============================================================================
// Module   : holding_fifo
// Purpose  : Depth-N first-word-fall-through queue between datapath stages.
//            Provides write/read strobes, occupancy count, full/empty flags,
//            synchronous clear and a sticky overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module holding_fifo #(
  parameter int word_size = 32,
  parameter int depth     = 4,
  localparam int cnt_size = $clog2(depth + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [word_size-1:0] input_data,
  input  logic                 write,
  input  logic                 read,
  input  logic                 clear,
  output logic [word_size-1:0] output_data,
  output logic                 empty,
  output logic                 full,
  output logic [cnt_size-1:0]  count,
  output logic                 overflow
);

  localparam int ptr_size = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [ptr_size-1:0] last_ptr  = ptr_size'(depth - 1);
  localparam logic [cnt_size-1:0] depth_cnt = cnt_size'(depth);

  logic [word_size-1:0] storage [depth];
  logic [ptr_size-1:0]  wr_ptr;
  logic [ptr_size-1:0]  rd_ptr;
  logic                 wr_ok;
  logic                 rd_ok;

  // Status flags and head word come straight from registered state.
  assign empty       = (count == '0);
  assign full        = (count == depth_cnt);
  assign output_data = empty ? '0 : storage[rd_ptr];

  // A write into a full queue is only taken when a read frees a slot in the
  // same cycle; clear suppresses both strobes.
  assign wr_ok = write & ~clear & (~full | read);
  assign rd_ok = read  & ~clear & ~empty;

  // Storage array carries no reset; unused entries are masked by empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      storage[wr_ptr] <= input_data;
    end
  end

  // Pointers wrap explicitly at depth-1 so non-power-of-two depths work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy moves only when exactly one of push/pop happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wr_ok && !rd_ok) begin
      count <= count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count <= count - 1'b1;
    end
  end

  // Sticky record of any write dropped because the queue was full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (write && full && !read) begin
      overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
